fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the rvsimple core, sitting directly upstream of the text memory and downstream consumers (decode). It owns the fetch PC, drives the word address into the combinational text memory, captures the returned instruction together with its PC into a 2-entry prefetch buffer, and presents instructions to decode over a valid/ready handshake. It handles control-flow redirects by flushing the buffer and restarting fetch, and it traps misaligned redirect targets.

## Interface
Parameters:
- TEXT_BITS, default rv_config::TEXT_BITS: byte-address width of the text region; the memory holds 2**(TEXT_BITS-2) words.
- RESET_PC, default 32'h0040_0000: fetch PC loaded on reset.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- imem_address  out  TEXT_BITS-2  word address to text memory = fetch_pc[TEXT_BITS-1:2].
- imem_q  in  32  instruction word returned combinationally for imem_address in the same cycle.
- redirect_valid  in  1  restart fetch at redirect_pc.
- redirect_pc  in  32  byte address of the new fetch target.
- inst_valid  out  1  buffer head holds a valid instruction.
- inst  out  32  instruction at buffer head.
- inst_pc  out  32  byte PC of the instruction at buffer head.
- inst_ready  in  1  consumer accepts the head this cycle.
- fault  out  1  misaligned redirect trapped; fetch halted.

## Operation
- State: fetch_pc (32 b), 2-entry FIFO of {inst, pc}, count (0..2), rd/wr pointers (1 b each), mode ∈ {RUN, FAULT}.
- pop = inst_valid & inst_ready.
- push = (mode==RUN) & !redirect_valid & (count<2 | pop). On push: FIFO[wr] ← {imem_q, fetch_pc}; fetch_pc ← fetch_pc + 4, modulo 2^32.
- The word address wraps naturally modulo the text size (upper PC bits are ignored for addressing); inst_pc carries the full 32-bit PC.
- count' = count + push − pop; pointers advance on push/pop respectively.
- Outputs inst_valid = (count!=0); inst and inst_pc = FIFO[rd]; these are driven from registers only, with no combinational path from inst_ready or redirect_*.
- imem_address is always driven from fetch_pc, including in FAULT mode.
- Redirect (redirect_valid=1), with priority over push:
  - An in-flight pop in the same cycle still counts as accepted.
  - The FIFO flushes: count ← 0, rd ← wr.
  - If redirect_pc[1:0]==0: fetch_pc ← redirect_pc and mode ← RUN. This also clears a previous FAULT.
  - Else: mode ← FAULT and fetch_pc ← redirect_pc.
- FAULT: no pushes; fault=1; inst_valid falls to 0 after the buffer drains. Exits only on an aligned redirect or on reset.
- Reset:
  - fetch_pc ← RESET_PC, count ← 0, pointers ← 0, mode ← RUN, FIFO contents ← 0.
  - Outputs after reset: inst_valid=0, inst=0, inst_pc=0, fault=0, imem_address=RESET_PC[TEXT_BITS-1:2].
  - Reset mid-stream discards all buffered instructions and any concurrent redirect.

## Timing
- Fetch-to-valid latency: 1 edge. The instruction at fetch_pc is sampled at edge E and is visible on inst/inst_valid after E.
- First instruction after reset: reset low at edge E0 → push at E0 → inst_valid=1, inst_pc=RESET_PC after E0.
- Throughput: 1 instruction/cycle with inst_ready held high; push and pop occur in the same cycle at count=2.
- Backpressure: at count=2 with inst_ready=0, fetch stalls and fetch_pc holds; inst/inst_pc must remain stable while inst_valid=1 and no pop or redirect occurs.
- Redirect penalty: redirect at edge E → inst_valid=0 after E; the target instruction is pushed at E+1 and visible with inst_pc=redirect_pc after E+1 (one bubble cycle).
- fault rises after the edge that samples a misaligned redirect and falls after the edge that samples an aligned one.

## Test plan
- Reset then stream: memory word n = n, RESET_PC=0x0040_0000, inst_ready=1 → inst_valid after the first edge; inst=0,1,2,… with inst_pc=0x0040_0000, 0x0040_0004, … on consecutive cycles with no bubbles.
- Backpressure: inst_ready=0 for 5 cycles → count saturates at 2, fetch_pc holds at RESET_PC+8, head stays inst=0; releasing inst_ready yields 0,1,2 in order with no loss or duplication.
- Redirect with full buffer and simultaneous pop: count=2, inst_ready=1, redirect_pc=0x0040_0100 → after the edge inst_valid=0; after the next edge inst_pc=0x0040_0100, inst=word 0x40; stale entries are never presented.
- Misaligned redirect: redirect_pc=0x0040_0102 → fault=1 and inst_valid=0 after the edge, with no further pushes over 10 cycles; a following redirect to 0x0040_0200 clears fault, and inst_pc=0x0040_0200 appears one cycle later.
- Wrap: TEXT_BITS=6, redirect to 0x0040_003C, stream → imem_address 15, 0, 1; inst_pc 0x0040_003C, 0x0040_0040, 0x0040_0044 (address wraps, PC does not); also redirect to 0xFFFF_FFFC → next inst_pc=0x0000_0000.
- Reset mid-operation: count=2, fault=0, assert reset together with redirect_valid for 1 cycle → all outputs at reset values; fetch resumes from RESET_PC, with the redirect ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a 2-entry {inst, pc} prefetch buffer,
// valid/ready delivery to decode, redirect flush and misaligned-target trap.
`default_nettype none

package rv_config;
  parameter int TEXT_BITS = 16;
endpackage

module fetch_unit #(
  parameter int          TEXT_BITS = rv_config::TEXT_BITS,
  parameter logic [31:0] RESET_PC  = 32'h0040_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [TEXT_BITS-3:0] imem_address,
  input  logic [31:0]          imem_q,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 inst_valid,
  output logic [31:0]          inst,
  output logic [31:0]          inst_pc,
  input  logic                 inst_ready,
  output logic                 fault
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } mode_t;

  mode_t       mode;
  mode_t       mode_next;
  logic [31:0] fetch_pc;
  logic [31:0] buf_inst [2];
  logic [31:0] buf_pc   [2];
  logic [1:0]  count;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        pop;
  logic        push;

  assign pop  = inst_valid & inst_ready;
  assign push = (mode == RUN) & ~redirect_valid & ((count != 2'd2) | pop);

  // Mode only changes on a redirect; alignment of the target decides RUN vs FAULT.
  always_comb begin
    mode_next = mode;
    if (redirect_valid) begin
      mode_next = (redirect_pc[1:0] == 2'b00) ? RUN : FAULT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode <= RUN;
    end else begin
      mode <= mode_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_inst[i] <= 32'h0;
        buf_pc[i]   <= 32'h0;
      end
    end else if (redirect_valid) begin
      // Flush: a concurrent pop is simply absorbed by collapsing rd onto wr.
      fetch_pc <= redirect_pc;
      count    <= 2'd0;
      rd_ptr   <= wr_ptr;
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= imem_q;
        buf_pc[wr_ptr]   <= fetch_pc;
        wr_ptr           <= ~wr_ptr;
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign imem_address = fetch_pc[TEXT_BITS-1:2];
  assign inst_valid   = (count != 2'd0);
  assign inst         = buf_inst[rd_ptr];
  assign inst_pc      = buf_pc[rd_ptr];
  assign fault        = (mode == FAULT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
`default_nettype none

module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] imem_address;
  logic [31:0] imem_q;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        fault;

  logic [3:0]  w_imem_address;
  logic [31:0] w_imem_q;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_inst_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Memory word n holds the value n.
  assign imem_q   = {18'h0, imem_address};
  assign w_imem_q = {28'h0, w_imem_address};

  fetch_unit #(.TEXT_BITS(16), .RESET_PC(RESET_PC)) dut (
    .clock(clk), .reset(reset), .imem_address(imem_address), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .fault(fault)
  );

  fetch_unit #(.TEXT_BITS(6), .RESET_PC(RESET_PC)) dut_w (
    .clock(clk), .reset(reset), .imem_address(w_imem_address), .imem_q(w_imem_q),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .inst_valid(w_inst_valid), .inst(w_inst), .inst_pc(w_inst_pc),
    .inst_ready(1'b1), .fault(w_fault)
  );

  typedef struct {
    logic [31:0] i;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc = RESET_PC;
  bit          m_fault = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {18'h0, pc[15:2]};
  endfunction

  function automatic logic [79:0] model_view();
    logic [31:0] ei, ep;
    ei = 32'h0;
    ep = 32'h0;
    if (m_q.size() != 0) begin
      ei = m_q[0].i;
      ep = m_q[0].pc;
    end
    return {m_q.size() != 0, m_fault, m_pc[15:2], ei, ep};
  endfunction

  function automatic logic [79:0] dut_view();
    return {inst_valid, fault, imem_address,
            inst_valid ? inst : 32'h0, inst_valid ? inst_pc : 32'h0};
  endfunction

  // Advance the reference model by one clock using the currently driven inputs.
  task automatic tick();
    bit   pop;
    ent_t e;
    pop = (m_q.size() != 0) && (inst_ready == 1'b1);
    if (reset) begin
      m_q.delete();
      m_pc    = RESET_PC;
      m_fault = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (redirect_valid) begin
        m_q.delete();
        m_pc    = redirect_pc;
        m_fault = (redirect_pc[1:0] != 2'b00);
      end else if (!m_fault && m_q.size() < 2) begin
        e.i  = mem_word(m_pc);
        e.pc = m_pc;
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inst_ready = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    total++;
    if ({inst_valid, fault, inst, inst_pc, imem_address} !== {1'b0, 1'b0, 32'h0, 32'h0, 14'h0}) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b f=%0b inst=%h pc=%h addr=%h want 0 0 0 0 0",
               inst_valid, fault, inst, inst_pc, imem_address);
    end
  endtask

  task automatic test_stream();
    reset = 1'b0;
    inst_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      total++;
      if ({inst_valid, inst, inst_pc} !== {1'b1, 32'(n), RESET_PC + 32'(4 * n)}) begin
        bad++;
        $display("FAIL stream[%0d] got v=%0b inst=%h pc=%h want v=1 inst=%h pc=%h",
                 n, inst_valid, inst, inst_pc, n, RESET_PC + 32'(4 * n));
      end
    end
  endtask

  task automatic test_backpressure();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    inst_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      total++;
      if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0, RESET_PC}) begin
        bad++;
        $display("FAIL bp_hold[%0d] got v=%0b inst=%h pc=%h want v=1 inst=0 pc=%h",
                 n, inst_valid, inst, inst_pc, RESET_PC);
      end
    end
    total++;
    if (imem_address !== 14'd2) begin
      bad++;
      $display("FAIL bp_fetch_pc got addr=%h want 2", imem_address);
    end
    inst_ready = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      tick();
      total++;
      if ({inst_valid, inst, inst_pc} !== {1'b1, 32'(n), RESET_PC + 32'(4 * n)}) begin
        bad++;
        $display("FAIL bp_release[%0d] got v=%0b inst=%h pc=%h want v=1 inst=%h",
                 n, inst_valid, inst, inst_pc, n);
      end
    end
  endtask

  task automatic test_redirect_full();
    inst_ready = 1'b0;
    tick();
    tick();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0100;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL redir_bubble got v=%0b want 0", inst_valid);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      total++;
      if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h40 + 32'(n), 32'h0040_0100 + 32'(4 * n)}) begin
        bad++;
        $display("FAIL redir_target[%0d] got v=%0b inst=%h pc=%h want v=1 inst=%h pc=%h",
                 n, inst_valid, inst, inst_pc, 32'h40 + 32'(n), 32'h0040_0100 + 32'(4 * n));
      end
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0102;
    tick();
    redirect_valid = 1'b0;
    for (int n = 0; n < 11; n++) begin
      total++;
      if ({fault, inst_valid, imem_address} !== {1'b1, 1'b0, 14'h40}) begin
        bad++;
        $display("FAIL fault_hold[%0d] got f=%0b v=%0b addr=%h want f=1 v=0 addr=40",
                 n, fault, inst_valid, imem_address);
      end
      inst_ready = 1'($urandom_range(0, 1));
      tick();
    end
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0200;
    tick();
    redirect_valid = 1'b0;
    total++;
    if ({fault, inst_valid} !== 2'b00) begin
      bad++;
      $display("FAIL fault_clear got f=%0b v=%0b want 0 0", fault, inst_valid);
    end
    tick();
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h80, 32'h0040_0200}) begin
      bad++;
      $display("FAIL fault_resume got v=%0b inst=%h pc=%h want 1 80 00400200",
               inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_wrap();
    logic [3:0]  exp_addr [4];
    logic [31:0] exp_pc   [4];
    exp_addr = '{4'd15, 4'd0, 4'd1, 4'd2};
    exp_pc   = '{32'h0, 32'h0040_003C, 32'h0040_0040, 32'h0040_0044};
    inst_ready = 1'b1;
    w_redirect_valid = 1'b1;
    w_redirect_pc = 32'h0040_003C;
    tick();
    w_redirect_valid = 1'b0;
    for (int n = 0; n < 4; n++) begin
      total++;
      if (w_imem_address !== exp_addr[n] ||
          (n > 0 && {w_inst_valid, w_inst_pc, w_inst} !== {1'b1, exp_pc[n], 28'h0, exp_addr[n] - 4'd1})) begin
        bad++;
        $display("FAIL wrap[%0d] got addr=%0d v=%0b pc=%h inst=%h want addr=%0d pc=%h",
                 n, w_imem_address, w_inst_valid, w_inst_pc, w_inst, exp_addr[n], exp_pc[n]);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h3FFF, 32'hFFFF_FFFC}) begin
      bad++;
      $display("FAIL pc_top got v=%0b inst=%h pc=%h want 1 3fff fffffffc", inst_valid, inst, inst_pc);
    end
    tick();
    total++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, 32'h0, 32'h0}) begin
      bad++;
      $display("FAIL pc_wrap got v=%0b inst=%h pc=%h want 1 0 0", inst_valid, inst, inst_pc);
    end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if ({inst_valid, fault} !== 2'b10) begin
      bad++;
      $display("FAIL rmid_setup got v=%0b f=%0b want 1 0", inst_valid, fault);
    end
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0040_0302;
    tick();
    reset = 1'b0;
    redirect_valid = 1'b0;
    total++;
    if ({inst_valid, fault, inst, inst_pc, imem_address} !== {1'b0, 1'b0, 32'h0, 32'h0, 14'h0}) begin
      bad++;
      $display("FAIL rmid_outputs got v=%0b f=%0b inst=%h pc=%h addr=%h want all 0",
               inst_valid, fault, inst, inst_pc, imem_address);
    end
    inst_ready = 1'b1;
    tick();
    total++;
    if ({inst_valid, fault, inst, inst_pc} !== {1'b1, 1'b0, 32'h0, RESET_PC}) begin
      bad++;
      $display("FAIL rmid_resume got v=%0b f=%0b inst=%h pc=%h want 1 0 0 %h",
               inst_valid, fault, inst, inst_pc, RESET_PC);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc = RESET_PC + 32'($urandom_range(0, 4095) << 2)
                    + (($urandom_range(0, 3) == 0) ? 32'd2 : 32'd0);
      reset = ($urandom_range(0, 63) == 0);
      tick();
      total++;
      if (dut_view() !== model_view()) begin
        bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d] got %h want %h", n, dut_view(), model_view());
      end
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
